input_frame_latch: RTL and testbench

INPUT_FRAME_LATCH -- requirements
Module: input_frame_latch

---
 rtl/input_frame_latch.sv | 185 ++++++++++++++++++
 tb/tb_input_frame_latch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_frame_latch.sv
// Debounces both players' raw button lines and latches them once per frame
// strobe, holding the latched frame until game_logic reports completion.
module input_frame_latch #(
    parameter int INPUT_DEPTH     = 5,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic [INPUT_DEPTH-1:0] p1_buttons,
    input  logic [INPUT_DEPTH-1:0] p2_buttons,
    input  logic                   frame_clk,
    input  logic                   done_gen,
    output logic [INPUT_DEPTH-1:0] p1_inputs,
    output logic [INPUT_DEPTH-1:0] p2_inputs,
    output logic                   inputs_valid,
    output logic [15:0]            frame_count,
    output logic [7:0]             overrun_count
);

    localparam int NBITS = 2 * INPUT_DEPTH;
    localparam int CW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        WAIT_DONE
    } state_t;

    logic [NBITS-1:0] raw_all;
    logic [NBITS-1:0] stable_all;

    assign raw_all = {p2_buttons, p1_buttons};

    // Per-bit synchronizer and debounce filter. The counter only runs while the
    // synchronized bit disagrees with the stable value, and stops at CNT_MAX.
    generate
        for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
            logic          s1_reg;
            logic          s2_reg;
            logic          stable_reg;
            logic          stable_next;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;

            always_comb begin
                cnt_next    = '0;
                stable_next = stable_reg;
                if (s2_reg != stable_reg) begin
                    if (cnt_reg == CNT_MAX) begin
                        stable_next = s2_reg;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge sys_clk or negedge rst) begin
                if (!rst) begin
                    s1_reg     <= 1'b0;
                    s2_reg     <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    s1_reg     <= raw_all[gi];
                    s2_reg     <= s1_reg;
                    stable_reg <= stable_next;
                    cnt_reg    <= cnt_next;
                end
            end

            assign stable_all[gi] = stable_reg;
        end
    endgenerate

    logic       frame_s1_reg;
    logic       frame_s2_reg;
    logic       frame_d_reg;
    logic       done_s1_reg;
    logic       done_s2_reg;
    logic       done_d_reg;
    logic [1:0] warm_reg;
    logic       frame_armed_reg;
    logic       frame_armed_next;
    logic       frame_edge;
    logic       done_edge;

    // warm_reg[1] marks the point where frame_s2_reg reflects a real sample
    // rather than its reset value; a frame edge is only accepted after the
    // synchronized strobe has genuinely been seen low since reset.
    assign frame_armed_next = frame_armed_reg | (warm_reg[1] & ~frame_s2_reg);
    assign frame_edge       = frame_armed_reg & frame_s2_reg & ~frame_d_reg;
    assign done_edge        = done_s2_reg & ~done_d_reg;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            frame_s1_reg    <= 1'b0;
            frame_s2_reg    <= 1'b0;
            frame_d_reg     <= 1'b0;
            done_s1_reg     <= 1'b0;
            done_s2_reg     <= 1'b0;
            done_d_reg      <= 1'b0;
            warm_reg        <= 2'b00;
            frame_armed_reg <= 1'b0;
        end else begin
            frame_s1_reg    <= frame_clk;
            frame_s2_reg    <= frame_s1_reg;
            frame_d_reg     <= frame_s2_reg;
            done_s1_reg     <= done_gen;
            done_s2_reg     <= done_s1_reg;
            done_d_reg      <= done_s2_reg;
            warm_reg        <= {warm_reg[0], 1'b1};
            frame_armed_reg <= frame_armed_next;
        end
    end

    state_t                 state_reg;
    state_t                 state_next;
    logic [INPUT_DEPTH-1:0] p1_reg;
    logic [INPUT_DEPTH-1:0] p1_next;
    logic [INPUT_DEPTH-1:0] p2_reg;
    logic [INPUT_DEPTH-1:0] p2_next;
    logic [15:0]            frame_count_reg;
    logic [15:0]            frame_count_next;
    logic [7:0]             overrun_count_reg;
    logic [7:0]             overrun_count_next;
    logic                   load;

    always_comb begin
        state_next         = state_reg;
        overrun_count_next = overrun_count_reg;
        load               = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_edge) begin
                    load = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (frame_edge && done_edge) begin
                    load = 1'b1;
                end else if (frame_edge) begin
                    if (overrun_count_reg != 8'hFF) begin
                        overrun_count_next = overrun_count_reg + 8'd1;
                    end
                end else if (done_edge) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        p1_next          = p1_reg;
        p2_next          = p2_reg;
        frame_count_next = frame_count_reg;
        if (load) begin
            p1_next          = stable_all[INPUT_DEPTH-1:0];
            p2_next          = stable_all[NBITS-1:INPUT_DEPTH];
            frame_count_next = frame_count_reg + 16'd1;
            state_next       = WAIT_DONE;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            p1_reg            <= '0;
            p2_reg            <= '0;
            frame_count_reg   <= '0;
            overrun_count_reg <= '0;
        end else begin
            state_reg         <= state_next;
            p1_reg            <= p1_next;
            p2_reg            <= p2_next;
            frame_count_reg   <= frame_count_next;
            overrun_count_reg <= overrun_count_next;
        end
    end

    assign p1_inputs     = p1_reg;
    assign p2_inputs     = p2_reg;
    assign inputs_valid  = (state_reg == WAIT_DONE);
    assign frame_count   = frame_count_reg;
    assign overrun_count = overrun_count_reg;

endmodule

// File: tb/tb_input_frame_latch.sv
// Directed bench for input_frame_latch: debounce, frame latency, overrun,
// aligned done/frame, asynchronous reset and frame counter wrap.
module tb_input_frame_latch;

    localparam int INPUT_DEPTH = 5;

    logic                   sys_clk;
    logic                   rst;
    logic [INPUT_DEPTH-1:0] p1_buttons;
    logic [INPUT_DEPTH-1:0] p2_buttons;
    logic                   frame_clk;
    logic                   done_gen;
    logic [INPUT_DEPTH-1:0] p1_inputs;
    logic [INPUT_DEPTH-1:0] p2_inputs;
    logic                   inputs_valid;
    logic [15:0]            frame_count;
    logic [7:0]             overrun_count;

    int checks_total;
    int checks_passed;

    input_frame_latch #(
        .INPUT_DEPTH    (INPUT_DEPTH),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .p1_buttons   (p1_buttons),
        .p2_buttons   (p2_buttons),
        .frame_clk    (frame_clk),
        .done_gen     (done_gen),
        .p1_inputs    (p1_inputs),
        .p2_inputs    (p2_inputs),
        .inputs_valid (inputs_valid),
        .frame_count  (frame_count),
        .overrun_count(overrun_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
            $display("check %-16s ok   value=0x%0h", tag, obs);
        end else begin
            $display("FAIL %-16s got=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_frame();
        @(negedge sys_clk);
        frame_clk = 1'b1;
        wait_neg(3);
        frame_clk = 1'b0;
        wait_neg(3);
    endtask

    task automatic pulse_done();
        @(negedge sys_clk);
        done_gen = 1'b1;
        wait_neg(3);
        done_gen = 1'b0;
        wait_neg(3);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst        = 1'b0;
        p1_buttons = '0;
        p2_buttons = '0;
        frame_clk  = 1'b0;
        done_gen   = 1'b0;

        wait_neg(3);
        check_eq("rst_valid", 32'(inputs_valid), 32'd0);
        check_eq("rst_p1", 32'(p1_inputs), 32'd0);
        check_eq("rst_fc", 32'(frame_count), 32'd0);
        check_eq("rst_oc", 32'(overrun_count), 32'd0);
        rst = 1'b1;

        // First frame: debounced 00001 appears exactly three edges after sampling
        p1_buttons = 5'b00001;
        wait_neg(20);
        frame_clk = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check_eq("latency_k1", 32'(inputs_valid), 32'd0);
        @(posedge sys_clk);
        #1;
        check_eq("latency_k2", 32'(inputs_valid), 32'd1);
        check_eq("f1_p1", 32'(p1_inputs), 32'h01);
        check_eq("f1_fc", 32'(frame_count), 32'd1);
        wait_neg(3);
        frame_clk = 1'b0;
        wait_neg(3);

        pulse_done();
        check_eq("done_valid", 32'(inputs_valid), 32'd0);
        check_eq("done_hold_p1", 32'(p1_inputs), 32'h01);

        // done edge in IDLE is ignored
        pulse_done();
        check_eq("idle_done_v", 32'(inputs_valid), 32'd0);
        check_eq("idle_done_fc", 32'(frame_count), 32'd1);

        // 10-cycle glitch must not survive debounce
        @(negedge sys_clk);
        p2_buttons = 5'b01000;
        wait_neg(10);
        p2_buttons = 5'b00000;
        wait_neg(5);
        pulse_frame();
        check_eq("glitch_p2", 32'(p2_inputs), 32'h00);
        check_eq("glitch_fc", 32'(frame_count), 32'd2);
        pulse_done();

        // A long press does pass
        p2_buttons = 5'b01000;
        wait_neg(25);
        pulse_frame();
        check_eq("press_p2", 32'(p2_inputs), 32'h08);
        check_eq("press_fc", 32'(frame_count), 32'd3);

        // Outputs frozen mid-frame, then aligned done+frame reloads
        p1_buttons = 5'b00110;
        wait_neg(25);
        check_eq("midframe_p1", 32'(p1_inputs), 32'h01);
        @(negedge sys_clk);
        frame_clk = 1'b1;
        done_gen  = 1'b1;
        wait_neg(3);
        frame_clk = 1'b0;
        done_gen  = 1'b0;
        wait_neg(3);
        check_eq("align_p1", 32'(p1_inputs), 32'h06);
        check_eq("align_fc", 32'(frame_count), 32'd4);
        check_eq("align_valid", 32'(inputs_valid), 32'd1);
        check_eq("align_oc", 32'(overrun_count), 32'd0);

        // Overrun: second frame without done
        pulse_done();
        pulse_frame();
        check_eq("ovr_first_fc", 32'(frame_count), 32'd5);
        p1_buttons = 5'b11000;
        wait_neg(25);
        pulse_frame();
        check_eq("ovr_oc1", 32'(overrun_count), 32'd1);
        check_eq("ovr_fc", 32'(frame_count), 32'd5);
        check_eq("ovr_p1", 32'(p1_inputs), 32'h06);
        for (int i = 0; i < 300; i++) pulse_frame();
        check_eq("ovr_sat", 32'(overrun_count), 32'hFF);
        check_eq("ovr_sat_fc", 32'(frame_count), 32'd5);

        // Asynchronous reset in WAIT_DONE with frame_clk left high
        pulse_done();
        p1_buttons = 5'b10101;
        wait_neg(25);
        frame_clk = 1'b1;
        wait_neg(5);
        check_eq("prerst_p1", 32'(p1_inputs), 32'h15);
        check_eq("prerst_valid", 32'(inputs_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_p1", 32'(p1_inputs), 32'd0);
        check_eq("arst_p2", 32'(p2_inputs), 32'd0);
        check_eq("arst_valid", 32'(inputs_valid), 32'd0);
        check_eq("arst_fc", 32'(frame_count), 32'd0);
        check_eq("arst_oc", 32'(overrun_count), 32'd0);
        @(negedge sys_clk);
        rst = 1'b1;
        wait_neg(30);
        check_eq("highrel_valid", 32'(inputs_valid), 32'd0);
        check_eq("highrel_fc", 32'(frame_count), 32'd0);
        frame_clk = 1'b0;
        wait_neg(4);
        frame_clk = 1'b1;
        wait_neg(5);
        check_eq("fresh_p1", 32'(p1_inputs), 32'h15);
        check_eq("fresh_fc", 32'(frame_count), 32'd1);
        frame_clk = 1'b0;

        // Frame counter wrap using one-cycle aligned handshakes
        @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        rst = 1'b1;
        wait_neg(5);
        for (int i = 0; i < 65535; i++) begin
            @(negedge sys_clk);
            frame_clk = 1'b1;
            done_gen  = 1'b1;
            @(negedge sys_clk);
            frame_clk = 1'b0;
            done_gen  = 1'b0;
        end
        wait_neg(5);
        check_eq("wrap_ffff", 32'(frame_count), 32'hFFFF);
        @(negedge sys_clk);
        frame_clk = 1'b1;
        done_gen  = 1'b1;
        @(negedge sys_clk);
        frame_clk = 1'b0;
        done_gen  = 1'b0;
        wait_neg(5);
        check_eq("wrap_zero", 32'(frame_count), 32'h0000);
        check_eq("wrap_oc", 32'(overrun_count), 32'd0);
        check_eq("wrap_valid", 32'(inputs_valid), 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
